// File: rtl/macarray_pkg.sv
// Shared constants and types for the MAC-array output path.
//   N   : rows/columns per tile
//   DW  : bits per column byte
//   PW  : width of a row/slot index
//   state_e : output-buffer control states
package macarray_pkg;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_e;
endpackage

// File: rtl/obuf_deskew_if.sv
// Signal bundle for the obuf_deskew data path.
//   master : array side + downstream ready (drives ORES/OCOL_VALID/ODST_i/OWORD_READY)
//   slave  : buffer side (drives OWORD/OROW/OWORD_VALID/ODST_o/BUSY/DONE/OVF)
interface obuf_deskew_if;
  import macarray_pkg::*;
  logic [N*DW-1:0] ORES;
  logic [N-1:0]    OCOL_VALID;
  logic [3:0]      ODST_i;
  logic [N*DW-1:0] OWORD;
  logic [PW-1:0]   OROW;
  logic            OWORD_VALID;
  logic            OWORD_READY;
  logic [3:0]      ODST_o;
  logic            BUSY;
  logic            DONE;
  logic            OVF;

  modport master (
    output ORES, OCOL_VALID, ODST_i, OWORD_READY,
    input  OWORD, OROW, OWORD_VALID, ODST_o, BUSY, DONE, OVF
  );
  modport slave (
    input  ORES, OCOL_VALID, ODST_i, OWORD_READY,
    output OWORD, OROW, OWORD_VALID, ODST_o, BUSY, DONE, OVF
  );
endinterface

// File: rtl/obuf_col.sv
// One column of the de-skew buffer: N x DW storage, write pointer and
// full flag.
//   wr_en/wr_data : capture a byte into slot ptr and advance ptr
//   clr           : clear ptr and full flag for the next tile
//   rd_idx/rd_data: combinational read of one slot
//   done          : all N slots captured
//   last          : next write fills the final slot
module obuf_col
  import macarray_pkg::*;
(
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          clr,
  input  logic [PW-1:0] rd_idx,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          last
);
  logic [DW-1:0] mem_q [N];
  logic [DW-1:0] mem_d [N];
  logic [PW-1:0] ptr_q, ptr_d;
  logic          done_q, done_d;

  always_comb begin
    mem_d  = mem_q;
    ptr_d  = ptr_q;
    done_d = done_q;
    if (clr) begin
      ptr_d  = '0;
      done_d = 1'b0;
    end else if (wr_en) begin
      mem_d[ptr_q] = wr_data;
      ptr_d        = ptr_q + PW'(1);
      if (ptr_q == PW'(N-1)) done_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr_q  <= '0;
      done_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      done_q <= done_d;
    end
  end

  // Storage needs no reset; outputs are gated by the top.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];
  assign done    = done_q;
  assign last    = (ptr_q == PW'(N-1));
endmodule

// File: rtl/obuf_deskew.sv
// Output de-skew buffer: collects a skewed 4x4 tile column by column and
// replays it row by row with a valid/ready handshake.
//   CLK, RSTN         : clock, async active-low reset
//   ORES, OCOL_VALID  : skewed column bytes and per-column valids
//   ODST_i / ODST_o   : tile tag in / tag latched at tile start
//   OWORD, OROW       : de-skewed row word and its index
//   OWORD_VALID/READY : output handshake
//   BUSY, DONE, OVF   : in-progress, end-of-tile pulse, sticky drop flag
module obuf_deskew
  import macarray_pkg::*;
(
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [N*DW-1:0] ORES,
  input  logic [N-1:0]  OCOL_VALID,
  input  logic [3:0]    ODST_i,
  output logic [N*DW-1:0] OWORD,
  output logic [PW-1:0] OROW,
  output logic          OWORD_VALID,
  input  logic          OWORD_READY,
  output logic [3:0]    ODST_o,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVF
);
  state_e        state_q, state_d;
  logic [PW-1:0] row_q, row_d;
  logic [3:0]    odst_q, odst_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;

  logic [N-1:0]  col_acc, col_done, col_last;
  logic          col_clr;
  logic [DW-1:0] col_rd [N];

  for (genvar j = 0; j < N; j++) begin : g_col
    obuf_col u_col (
      .CLK     (CLK),
      .RSTN    (RSTN),
      .wr_en   (col_acc[j]),
      .wr_data (ORES[DW*(N-1-j) +: DW]),
      .clr     (col_clr),
      .rd_idx  (row_q),
      .rd_data (col_rd[j]),
      .done    (col_done[j]),
      .last    (col_last[j])
    );
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    odst_d  = odst_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    col_acc = '0;
    col_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (OCOL_VALID[0]) begin
          col_acc = OCOL_VALID;
          odst_d  = ODST_i;
          state_d = COLLECT;
        end else if (|OCOL_VALID[N-1:1]) begin
          ovf_d = 1'b1;
        end
      end
      COLLECT: begin
        col_acc = OCOL_VALID & ~col_done;
        if (|(OCOL_VALID & col_done)) ovf_d = 1'b1;
        // Leave on the edge that captures the final byte so DRAIN starts
        // in the cycle right after the col3 row-3 capture.
        if (&(col_done | (col_acc & col_last))) state_d = DRAIN;
      end
      DRAIN: begin
        if (|OCOL_VALID) ovf_d = 1'b1;
        if (OWORD_READY) begin
          if (row_q == PW'(N-1)) begin
            row_d   = '0;
            col_clr = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      row_q   <= '0;
      odst_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      odst_q  <= odst_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    OWORD = '0;
    if (state_q == DRAIN) begin
      for (int unsigned j = 0; j < N; j++) begin
        OWORD[DW*(N-1-j) +: DW] = col_rd[j];
      end
    end
  end

  assign OWORD_VALID = (state_q == DRAIN);
  assign OROW        = row_q;
  assign ODST_o      = odst_q;
  assign BUSY        = (state_q != IDLE);
  assign DONE        = done_q;
  assign OVF         = ovf_q;
endmodule

// File: tb/tb_obuf_deskew.sv
module tb_obuf_deskew;
  logic clk;
  logic rstn;

  obuf_deskew_if bus ();

  obuf_deskew dut (
    .CLK         (clk),
    .RSTN        (rstn),
    .ORES        (bus.ORES),
    .OCOL_VALID  (bus.OCOL_VALID),
    .ODST_i      (bus.ODST_i),
    .OWORD       (bus.OWORD),
    .OROW        (bus.OROW),
    .OWORD_VALID (bus.OWORD_VALID),
    .OWORD_READY (bus.OWORD_READY),
    .ODST_o      (bus.ODST_o),
    .BUSY        (bus.BUSY),
    .DONE        (bus.DONE),
    .OVF         (bus.OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  row;
    logic [3:0]  dst;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int r, input int c, input logic [7:0] mask);
    return {4'(r), 4'(c)} ^ mask;
  endfunction

  // Compare any handshake against the scoreboard, then advance one cycle.
  task automatic tick();
    exp_t e;
    if (bus.OWORD_VALID === 1'b1 && bus.OWORD_READY === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_row", 32'(bus.OWORD_VALID), 32'(0));
      end else begin
        e = sb.pop_front();
        check("oword", bus.OWORD, e.word);
        check("orow", 32'(bus.OROW), 32'(e.row));
        check("odst_o", 32'(bus.ODST_o), 32'(e.dst));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drive ncyc cycles of a skewed tile; extra2 adds a 5th col2 pulse.
  task automatic drive_tile(input logic [3:0] dst, input logic [7:0] mask,
                            input int ncyc, input bit extra2);
    logic [31:0] d;
    logic [3:0]  v;
    exp_t e;
    if (ncyc == 7) begin
      for (int r = 0; r < 4; r++) begin
        e.word = {byte_of(r,0,mask), byte_of(r,1,mask), byte_of(r,2,mask), byte_of(r,3,mask)};
        e.row  = 2'(r);
        e.dst  = dst;
        sb.push_back(e);
      end
    end
    for (int c = 0; c < ncyc; c++) begin
      v = '0;
      d = '0;
      for (int j = 0; j < 4; j++) begin
        if (c - j >= 0 && c - j < 4) begin
          v[j] = 1'b1;
          d[8*(3-j) +: 8] = byte_of(c - j, j, mask);
        end
      end
      if (extra2 && c == 6) begin
        v[2] = 1'b1;
        d[15:8] = 8'hEE;
      end
      bus.OCOL_VALID = v;
      bus.ORES       = d;
      bus.ODST_i     = (c == 0) ? dst : ~dst;
      tick();
      if (c == 0) check("odst_latch", 32'(bus.ODST_o), 32'(dst));
      if (c < 6) begin
        check("valid_low_collect", 32'(bus.OWORD_VALID), 32'(0));
        check("busy_collect", 32'(bus.BUSY), 32'(1));
      end
    end
    bus.OCOL_VALID = '0;
    bus.ORES       = '0;
    bus.ODST_i     = '0;
  endtask

  // Drain all expected rows, optionally stalling at one row; ends in the DONE cycle.
  task automatic drain(input int stall_row, input int stall_n, output int cycles);
    int stalls;
    int budget;
    stalls = stall_n;
    budget = 40;
    cycles = 0;
    check("first_valid", 32'(bus.OWORD_VALID), 32'(1));
    while (sb.size() > 0 && budget > 0) begin
      if (bus.OWORD_VALID === 1'b1 && int'(bus.OROW) == stall_row && stalls > 0) begin
        bus.OWORD_READY = 1'b0;
        stalls--;
        check("hold_word", bus.OWORD, sb[0].word);
        check("hold_row", 32'(bus.OROW), 32'(sb[0].row));
        check("hold_dst", 32'(bus.ODST_o), 32'(sb[0].dst));
      end else begin
        bus.OWORD_READY = 1'b1;
      end
      tick();
      budget--;
      cycles++;
    end
    check("drain_timeout", 32'(sb.size()), 32'(0));
    bus.OWORD_READY = 1'b1;
    check("done_pulse", 32'(bus.DONE), 32'(1));
    check("busy_done_cycle", 32'(bus.BUSY), 32'(0));
    check("valid_done_cycle", 32'(bus.OWORD_VALID), 32'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_oword"}, bus.OWORD, 32'h0);
    check({tag, "_orow"}, 32'(bus.OROW), 32'(0));
    check({tag, "_odst"}, 32'(bus.ODST_o), 32'(0));
    check({tag, "_valid"}, 32'(bus.OWORD_VALID), 32'(0));
    check({tag, "_busy"}, 32'(bus.BUSY), 32'(0));
    check({tag, "_done"}, 32'(bus.DONE), 32'(0));
    check({tag, "_ovf"}, 32'(bus.OVF), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rstn            = 1'b0;
    bus.ORES        = '0;
    bus.OCOL_VALID  = '0;
    bus.ODST_i      = '0;
    bus.OWORD_READY = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Nominal tile, exact latency.
    drive_tile(4'h5, 8'h00, 7, 1'b0);
    drain(-1, 0, cyc);
    check("nominal_drain_cycles", 32'(cyc), 32'(4));
    check("nominal_ovf", 32'(bus.OVF), 32'(0));

    // Back-to-back: second tile starts in the DONE cycle.
    drive_tile(4'hA, 8'hC0, 7, 1'b0);
    drain(-1, 0, cyc);
    check("b2b_drain_cycles", 32'(cyc), 32'(4));
    tick();
    check("done_one_cycle", 32'(bus.DONE), 32'(0));

    // Backpressure: 3 stalled cycles at row 1.
    drive_tile(4'h3, 8'h44, 7, 1'b0);
    drain(1, 3, cyc);
    check("bp_drain_cycles", 32'(cyc), 32'(7));
    check("bp_ovf", 32'(bus.OVF), 32'(0));
    tick();

    // Overflow: 5th col2 pulse is dropped, data intact, flag sticky.
    drive_tile(4'h9, 8'h00, 7, 1'b1);
    check("ovf_set", 32'(bus.OVF), 32'(1));
    drain(-1, 0, cyc);
    tick();
    tick();
    check("ovf_sticky", 32'(bus.OVF), 32'(1));

    // Stray upper-column valid while idle sets the flag only.
    bus.OCOL_VALID = 4'b0100;
    tick();
    bus.OCOL_VALID = '0;
    check("idle_stray_busy", 32'(bus.BUSY), 32'(0));

    // Reset mid-tile after two columns filled, then a clean tile.
    drive_tile(4'h7, 8'h11, 5, 1'b0);
    check("midtile_busy", 32'(bus.BUSY), 32'(1));
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    check_all_zero("midreset_hold");
    rstn = 1'b1;
    tick();
    drive_tile(4'hE, 8'h88, 7, 1'b0);
    drain(-1, 0, cyc);
    check("post_reset_drain_cycles", 32'(cyc), 32'(4));
    check("post_reset_ovf", 32'(bus.OVF), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
